// File: rtl/uart_pkg.sv
// Shared UART transmitter types: parity selection and the frame FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional bit-rate generator: adds BAUD per cycle and ticks on wrap past CLK_HZ.
// Combinational tick, no backpressure; accumulator held at zero while disabled.
module uart_baud_gen #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic tick_o
);
    localparam int AW = $clog2(CLK_HZ + BAUD);
    localparam logic [AW-1:0] STEP = AW'(BAUD);
    localparam logic [AW-1:0] WRAP = AW'(CLK_HZ);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] sum;

    always_comb begin
        sum    = acc_q + STEP;
        tick_o = enable_i && (sum >= WRAP);
        acc_d  = '0;
        if (enable_i) begin
            acc_d = tick_o ? (sum - WRAP) : sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO of characters, framed start/data/parity/stop, registered line.
// First start bit one cycle after a write into an idle empty block; writes while full are dropped and flagged.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int      CLK_HZ     = 12000000,
    parameter int      BAUD       = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_ni,
    input  logic                          uart_wr_i,
    input  logic [DATA_BITS-1:0]          uart_dat_i,
    output logic                          uart_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
    output logic                          uart_busy_o,
    output logic                          uart_ovf_o,
    output logic                          uart_tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic [AW:0]          level;
    logic [DATA_BITS-1:0] head;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 last_stop;
    logic                 ovf_q;
    logic                 armed_q;

    state_e               state_q;
    logic                 tx_q;
    logic [DATA_BITS-1:0] sh_q;
    logic [3:0]           cnt_q;
    logic                 par_q;
    logic                 stop_q;

    assign level       = wr_ptr_q - rd_ptr_q;
    assign empty       = (level == '0);
    assign uart_full_o = (level == (AW+1)'(FIFO_DEPTH));
    assign push        = uart_wr_i & ~uart_full_o;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign last_stop   = (STOP_BITS == 1) || stop_q;

    // A pop in STOP lands exactly on the stop-bit boundary, giving back-to-back frames.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            pop = ((state_q == IDLE) && armed_q) ||
                  ((state_q == STOP) && tick && last_stop);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= uart_dat_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q   <= uart_wr_i & uart_full_o;
            armed_q <= 1'b1;
        end
    end

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud (
        .clk_i    (sys_clk_i),
        .rst_ni   (sys_rst_ni),
        .enable_i (state_q != IDLE),
        .tick_o   (tick)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            sh_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            sh_q    <= head;
            par_q   <= (^head) ^ (PARITY == PAR_ODD);
            stop_q  <= 1'b0;
        end else if (tick) begin
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                    cnt_q   <= '0;
                end
                DATA: begin
                    if (cnt_q == 4'(DATA_BITS - 1)) begin
                        stop_q <= 1'b0;
                        if (PARITY != PAR_NONE) begin
                            state_q <= PAR;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        tx_q  <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                    stop_q  <= 1'b0;
                end
                STOP: begin
                    if (last_stop) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        stop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_level_o = level;
    assign uart_busy_o  = !empty || (state_q != IDLE);
    assign uart_ovf_o   = ovf_q;
    assign uart_tx_o    = tx_q;

endmodule
